// File: rtl/mem_mapper.sv
// Address-decoding memory mapper. It decodes a CPU access to one of NREG
// regions, holds the address and data for a per-region number of wait states,
// then strobes the write (or captures the read data) and pulses cpu_ready.
// Optional fault capture for unmapped accesses is compiled in when the macro
// MEMMAP_FAULT_EN is defined; without it the fault outputs are tied to 0.
module mem_mapper #(
  parameter int unsigned AW   = 16,
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 4,
  parameter logic [NREG*AW-1:0] REG_BASE = {16'h8000, 16'hB000, 16'h0000, 16'hE000},
  parameter logic [NREG*AW-1:0] REG_MASK = {16'hF000, 16'hF000, 16'hC000, 16'hE000},
  parameter logic [NREG*4-1:0]  REG_WAIT = {4'd1, 4'd2, 4'd0, 4'd0}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_ready,
  output logic [NREG-1:0]   dev_sel,
  output logic [NREG-1:0]   dev_we,
  output logic [AW-1:0]     dev_addr,
  output logic [DW-1:0]     dev_wdata,
  input  logic [NREG*DW-1:0] dev_rdata,
  output logic              fault_valid,
  output logic [AW-1:0]     fault_addr,
  input  logic              fault_clr
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e          state_q, state_d;
  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic            accept;
  logic [IW-1:0]   idx_q;
  logic            we_q;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;

  // Region decode: lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < int'(NREG); k++) begin
      if (!hit && ((cpu_addr & REG_MASK[k*AW +: AW]) ==
                   (REG_BASE[k*AW +: AW] & REG_MASK[k*AW +: AW]))) begin
        hit     = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end

  assign accept = (state_q == StIdle) && cpu_req;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only looked at in idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          state_d = hit ? StAccess : StDone;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: latch the request, count wait states, capture read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      idx_q   <= hit_idx;
      we_q    <= cpu_we;
      addr_q  <= cpu_addr;
      wdata_q <= cpu_wdata;
      cnt_q   <= hit ? REG_WAIT[hit_idx*4 +: 4] : 4'd0;
      // Unmapped reads return zero.
      if (!hit && !cpu_we) begin
        rdata_q <= '0;
      end
    end else if (state_q == StAccess) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end else if (!we_q) begin
        rdata_q <= dev_rdata[idx_q*DW +: DW];
      end
    end
  end

  // Outputs decoded from state; the write strobe is suppressed while reset
  // is asserted so an aborted access never strobes the device.
  always_comb begin
    dev_sel   = '0;
    dev_we    = '0;
    cpu_ready = 1'b0;
    unique case (state_q)
      StAccess: begin
        dev_sel[idx_q] = 1'b1;
        if ((cnt_q == '0) && we_q && !reset) begin
          dev_we[idx_q] = 1'b1;
        end
      end
      StDone:  cpu_ready = 1'b1;
      default: ;
    endcase
  end

  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;
  assign cpu_rdata = rdata_q;

`ifdef MEMMAP_FAULT_EN
  logic          fault_valid_q;
  logic [AW-1:0] fault_addr_q;

  // Sticky capture of the first unmapped address; a new fault in the same
  // cycle as a clear wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
    end else if (accept && !hit && (!fault_valid_q || fault_clr)) begin
      fault_valid_q <= 1'b1;
      fault_addr_q  <= cpu_addr;
    end else if (fault_clr) begin
      fault_valid_q <= 1'b0;
    end
  end

  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign fault_valid      = 1'b0;
  assign fault_addr       = '0;
`endif

endmodule

// File: tb/tb_mem_mapper.sv
// Self-checking bench for mem_mapper: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a decode model.
module tb_mem_mapper;

`ifdef MEMMAP_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic [3:0]  dev_sel;
  logic [3:0]  dev_we;
  logic [15:0] dev_addr;
  logic [7:0]  dev_wdata;
  logic [31:0] dev_rdata;
  logic        fault_valid;
  logic [15:0] fault_addr;
  logic        fault_clr;

  // Second instance with region 1 overlapping region 0, for priority.
  logic [7:0]  p_rdata;
  logic        p_ready;
  logic [3:0]  p_sel;
  logic [3:0]  p_we;
  logic [15:0] p_addr;
  logic [7:0]  p_wdata;
  logic        p_fv;
  logic [15:0] p_fa;

  always #5 clk = ~clk;

  mem_mapper u_dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .dev_sel(dev_sel), .dev_we(dev_we),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_clr(fault_clr)
  );

  mem_mapper #(
    .REG_BASE({16'h8000, 16'hB000, 16'hE000, 16'hE000}),
    .REG_MASK({16'hF000, 16'hF000, 16'hF000, 16'hE000})
  ) u_dut_prio (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(p_rdata),
    .cpu_ready(p_ready), .dev_sel(p_sel), .dev_we(p_we),
    .dev_addr(p_addr), .dev_wdata(p_wdata), .dev_rdata(dev_rdata),
    .fault_valid(p_fv), .fault_addr(p_fa), .fault_clr(fault_clr)
  );

  // Reference memory map (region 0 first).
  logic [15:0] ref_base [4] = '{16'hE000, 16'h0000, 16'hB000, 16'h8000};
  logic [15:0] ref_mask [4] = '{16'hE000, 16'hC000, 16'hF000, 16'hF000};
  int          ref_wait [4] = '{0, 0, 2, 1};

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [7:0]  model_rdata;
  logic        fv_m;
  logic [15:0] fa_m;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [31:0] bus;
    logic [3:0]  sel;
    int          lat;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs [10];

  function automatic int ref_region(input logic [15:0] a);
    for (int k = 0; k < 4; k++) begin
      if ((a & ref_mask[k]) == (ref_base[k] & ref_mask[k])) return k;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0; fault_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_rdata = 8'h00; fv_m = 1'b0; fa_m = 16'h0000;
  endtask

  // One complete transaction starting from idle; checks every cycle up to ready.
  task automatic run_txn(input string name, input logic [15:0] addr, input logic we,
                         input logic [7:0] wdata, input logic [31:0] bus, input logic clr,
                         input logic [3:0] exp_sel, input int lat, input logic [7:0] exp_rdata);
    logic in_acc;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    dev_rdata = bus; fault_clr = clr;
    if (FAULT_EN) begin
      if (exp_sel == 4'b0 && (!fv_m || clr)) begin
        fv_m = 1'b1; fa_m = addr;
      end else if (clr) begin
        fv_m = 1'b0;
      end
    end
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      in_acc = (c < lat);
      check({name, "/sel"}, 32'(dev_sel), in_acc ? 32'(exp_sel) : 32'h0);
      check({name, "/we"}, 32'(dev_we), (in_acc && c == lat - 1 && we) ? 32'(exp_sel) : 32'h0);
      check({name, "/ready"}, 32'(cpu_ready), (c == lat) ? 32'h1 : 32'h0);
      if (in_acc) begin
        check({name, "/addr"}, 32'(dev_addr), 32'(addr));
        check({name, "/wdata"}, 32'(dev_wdata), 32'(wdata));
      end
      if (c == 1) begin
        check({name, "/fvalid"}, 32'(fault_valid), 32'(fv_m));
        if (fv_m) check({name, "/faddr"}, 32'(fault_addr), 32'(fa_m));
        cpu_req = 1'b0; fault_clr = 1'b0;
      end
    end
    check({name, "/rdata"}, 32'(cpu_rdata), 32'(exp_rdata));
    model_rdata = exp_rdata;
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dev_rdata = '0; fault_clr = 1'b0;
    model_rdata = 8'h00; fv_m = 1'b0; fa_m = 16'h0000;

    vecs[0] = '{16'hE123, 1'b0, 8'h00, 32'h112233A5, 4'b0001, 2, 8'hA5};
    vecs[1] = '{16'hB010, 1'b1, 8'h3C, 32'hDEADBEEF, 4'b0100, 4, 8'hA5};
    vecs[2] = '{16'h5000, 1'b0, 8'h00, 32'hDEADBEEF, 4'b0000, 1, 8'h00};
    vecs[3] = '{16'h8123, 1'b0, 8'h00, 32'h5A445566, 4'b1000, 3, 8'h5A};
    vecs[4] = '{16'h0040, 1'b0, 8'h00, 32'h0102C304, 4'b0010, 2, 8'hC3};
    vecs[5] = '{16'h3FFF, 1'b1, 8'h9E, 32'hDEADBEEF, 4'b0010, 2, 8'hC3};
    vecs[6] = '{16'hBFFF, 1'b0, 8'h00, 32'h887799AA, 4'b0100, 4, 8'h77};
    vecs[7] = '{16'h6000, 1'b1, 8'h42, 32'hDEADBEEF, 4'b0000, 1, 8'h77};
    vecs[8] = '{16'hFFFF, 1'b0, 8'h00, 32'hFEDCBA11, 4'b0001, 2, 8'h11};
    vecs[9] = '{16'hC000, 1'b0, 8'h00, 32'hDEADBEEF, 4'b0000, 1, 8'h00};

    do_reset();

    // Reset state.
    check("rst/rdata", 32'(cpu_rdata), 0);
    check("rst/ready", 32'(cpu_ready), 0);
    check("rst/sel", 32'(dev_sel), 0);
    check("rst/we", 32'(dev_we), 0);
    check("rst/addr", 32'(dev_addr), 0);
    check("rst/wdata", 32'(dev_wdata), 0);
    check("rst/fvalid", 32'(fault_valid), 0);
    check("rst/faddr", 32'(fault_addr), 0);

    // Priority: region 0 wins over an overlapping region 1.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hE800; cpu_wdata = 8'h5D;
    dev_rdata = 32'h44332211;
    @(posedge clk);
    @(negedge clk);
    check("prio/sel", 32'(p_sel), 32'h1);
    check("prio/main_sel", 32'(dev_sel), 32'h1);
    check("prio/addr", 32'(p_addr), 32'hE800);
    check("prio/wdata", 32'(p_wdata), 32'h5D);
    check("prio/we", 32'(p_we), 0);
    cpu_req = 1'b0;
    @(negedge clk);
    check("prio/ready", 32'(p_ready), 1);
    check("prio/rdata", 32'(p_rdata), 32'h11);
    check("prio/fvalid", 32'(p_fv), 0);
    check("prio/faddr", 32'(p_fa), 0);
    check("prio/main_rdata", 32'(cpu_rdata), 32'h11);
    model_rdata = 8'h11;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].bus,
              1'b0, vecs[i].sel, vecs[i].lat, vecs[i].rdata);
    end

    // Request held high through done is taken again in the next idle cycle.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hE123; dev_rdata = 32'h000000B7;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("hold/ready%0d", c), 32'(cpu_ready), (c == 2 || c == 5) ? 1 : 0);
      check($sformatf("hold/sel%0d", c), 32'(dev_sel), (c == 1 || c == 4) ? 1 : 0);
      if (c == 5) cpu_req = 1'b0;
    end
    check("hold/rdata", 32'(cpu_rdata), 32'hB7);
    model_rdata = 8'hB7;

    // Fault capture, sticky hold, and clear-with-new-fault.
    do_reset();
    run_txn("flt1", 16'h5000, 1'b0, 8'h00, 32'h0, 1'b0, 4'b0000, 1, 8'h00);
    run_txn("flt2", 16'h6000, 1'b0, 8'h00, 32'h0, 1'b0, 4'b0000, 1, 8'h00);
`ifdef MEMMAP_FAULT_EN
    check("flt2/keep_addr", 32'(fault_addr), 32'h5000);
`endif
    run_txn("flt3", 16'h7000, 1'b0, 8'h00, 32'h0, 1'b1, 4'b0000, 1, 8'h00);
`ifdef MEMMAP_FAULT_EN
    check("flt3/valid", 32'(fault_valid), 1);
    check("flt3/addr", 32'(fault_addr), 32'h7000);
`endif
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    fv_m = 1'b0;
    check("fltclr/valid", 32'(fault_valid), 0);

    // Reset in the middle of an access aborts it.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'h99;
    @(posedge clk);
    @(negedge clk);
    check("abort/sel", 32'(dev_sel), 32'h8);
    check("abort/we", 32'(dev_we), 0);
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_rdata = 8'h00; fv_m = 1'b0; fa_m = 16'h0;
    check("abort/rdata", 32'(cpu_rdata), 0);
    check("abort/sel0", 32'(dev_sel), 0);
    check("abort/addr", 32'(dev_addr), 0);
    check("abort/wdata", 32'(dev_wdata), 0);
    check("abort/fvalid", 32'(fault_valid), 0);
    for (int c = 0; c < 4; c++) begin
      check("abort/ready", 32'(cpu_ready), 0);
      check("abort/we_after", 32'(dev_we), 0);
      @(negedge clk);
    end

    // Randomized traffic against the decode model.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      logic        w;
      logic [7:0]  wd;
      logic [31:0] bus;
      logic        clr;
      int          r;
      logic [3:0]  sel;
      int          lat;
      logic [7:0]  rd;
      a   = 16'($urandom_range(0, 16'hFFFF));
      w   = 1'($urandom_range(0, 1));
      wd  = 8'($urandom);
      bus = $urandom;
      clr = ($urandom_range(0, 7) == 0);
      r   = ref_region(a);
      sel = (r < 0) ? 4'b0000 : 4'(1 << r);
      lat = (r < 0) ? 1 : 2 + ref_wait[r];
      if (w) rd = model_rdata;
      else if (r < 0) rd = 8'h00;
      else rd = bus[r*8 +: 8];
      run_txn($sformatf("rnd%0d", i), a, w, wd, bus, clr, sel, lat, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
